qcs_dyn_pre_seq_ctrl: RTL and testbench

Sequencer for the dynamic preamble generator. It accepts one preamble job per start handshake, latches the TX configuration, and drives it stable onto the generator's config inputs. It then issues a burst of `nhtp_re`/`nhtp_raddr` table reads, throttled by downstream backpressure, and signals completion once the generator's read pipeline has drained. It sits between the TX control FSM and `qcs_dyn_pre_gen`.

---
 rtl/qcs_dyn_pre_seq_pkg.sv | 31 +++
 rtl/qcs_dyn_pre_seq_addr_gen.sv | 55 +++++
 rtl/qcs_dyn_pre_seq_ctrl.sv | 168 ++++++++++++++++
 tb/tb_qcs_dyn_pre_seq_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qcs_dyn_pre_seq_pkg.sv
// Shared types and defaults for the dynamic preamble sequencer.
// The optional abort input is enabled by the macro QCS_DYN_PRE_SEQ_ABORT_EN.
`timescale 1ns/1ps
package qcs_dyn_pre_seq_pkg;

  localparam int ADDR_DW_DEF   = 14;
  localparam int BW_W_DEF      = 2;
  localparam int GAMMA_W_DEF   = 4;
  localparam int SUBBAND_W_DEF = 8;
  localparam int N_TX_W        = 4;
  localparam int RD_LAT_DEF    = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_READ  = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_t;

  // Latched job configuration; field widths follow the package defaults.
  typedef struct packed {
    logic [BW_W_DEF-1:0]      pkt_bw;
    logic [BW_W_DEF-1:0]      sys_bw;
    logic [SUBBAND_W_DEF-1:0] subband;
    logic [GAMMA_W_DEF-1:0]   gamma;
    logic [N_TX_W-1:0]        n_tx;
    logic                     ch4;
  } seq_cfg_t;

endpackage

// File: rtl/qcs_dyn_pre_seq_addr_gen.sv
// Read address generator: holds the job base, the read index and the
// count of reads still owed. Address wraps modulo 2^ADDR_DW.
`timescale 1ns/1ps
module qcs_dyn_pre_seq_addr_gen #(
  parameter int ADDR_DW = 14
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic [ADDR_DW-1:0] base,
  input  logic [ADDR_DW:0]   len,
  input  logic               advance,
  output logic [ADDR_DW-1:0] addr,
  output logic               last,
  output logic               empty
);

  logic [ADDR_DW-1:0] base_q, base_d;
  logic [ADDR_DW-1:0] idx_q, idx_d;
  logic [ADDR_DW:0]   rem_q, rem_d;

  // Load a new job or step to the next read.
  always_comb begin
    base_d = base_q;
    idx_d  = idx_q;
    rem_d  = rem_q;
    if (load) begin
      base_d = base;
      idx_d  = '0;
      rem_d  = len;
    end else if (advance && (rem_q != '0)) begin
      idx_d = idx_q + ADDR_DW'(1);
      rem_d = rem_q - (ADDR_DW+1)'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_q <= '0;
      idx_q  <= '0;
      rem_q  <= '0;
    end else begin
      base_q <= base_d;
      idx_q  <= idx_d;
      rem_q  <= rem_d;
    end
  end

  // Truncating add gives the silent wrap at the top of the table.
  assign addr  = base_q + idx_q;
  assign last  = (rem_q == (ADDR_DW+1)'(1));
  assign empty = (rem_q == '0);

endmodule

// File: rtl/qcs_dyn_pre_seq_ctrl.sv
// Dynamic preamble sequencer: accepts a job, latches config, issues a
// throttled burst of table reads, waits for the read pipeline to drain,
// then pulses done. Define QCS_DYN_PRE_SEQ_ABORT_EN to add the abort input.
//
// Handshake: a job transfers on a clock edge where start_valid and
// start_ready are both high; cfg_* must be stable while start_valid is high
// and the requester holds start_valid until it sees start_ready.
`timescale 1ns/1ps
module qcs_dyn_pre_seq_ctrl
  import qcs_dyn_pre_seq_pkg::*;
#(
  parameter int ADDR_DW   = ADDR_DW_DEF,
  parameter int BW_W      = BW_W_DEF,
  parameter int GAMMA_W   = GAMMA_W_DEF,
  parameter int SUBBAND_W = SUBBAND_W_DEF,
  parameter int RD_LAT    = RD_LAT_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [BW_W-1:0]      cfg_pkt_bw,
  input  logic [BW_W-1:0]      cfg_sys_bw,
  input  logic [SUBBAND_W-1:0] cfg_subband,
  input  logic [GAMMA_W-1:0]   cfg_gamma,
  input  logic [3:0]           cfg_n_tx,
  input  logic                 cfg_4ch,
  input  logic [ADDR_DW-1:0]   cfg_base_addr,
  input  logic [ADDR_DW:0]     cfg_len,
  input  logic                 out_ready,
`ifdef QCS_DYN_PRE_SEQ_ABORT_EN
  input  logic                 abort,
`endif
  output logic                 nhtp_re,
  output logic [ADDR_DW-1:0]   nhtp_raddr,
  output logic [BW_W-1:0]      txconfig_bw,
  output logic [BW_W-1:0]      sys_bw_mode,
  output logic [SUBBAND_W-1:0] config_mu_subband_present,
  output logic [GAMMA_W-1:0]   config_gamma_rotation,
  output logic [3:0]           n_tx,
  output logic                 nhtp_4ch,
  output logic                 busy,
  output logic                 done,
  output logic [2:0]           dbg_state
);

  localparam int FC_W = $clog2(RD_LAT + 1);

  seq_state_t         state_q, state_d;
  seq_cfg_t           cfg_q, cfg_d;
  logic               nhtp_re_q, nhtp_re_d;
  logic [ADDR_DW-1:0] nhtp_raddr_q, nhtp_raddr_d;
  logic [FC_W-1:0]    flush_cnt_q, flush_cnt_d;
  logic               ready_en_q, ready_en_d;
  logic               ag_load, ag_advance, ag_last, ag_empty;
  logic [ADDR_DW-1:0] ag_addr;
  logic               abort_i;

`ifdef QCS_DYN_PRE_SEQ_ABORT_EN
  assign abort_i = abort;
`else
  assign abort_i = 1'b0;
`endif

  qcs_dyn_pre_seq_addr_gen #(.ADDR_DW(ADDR_DW)) u_addr_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (ag_load),
    .base    (cfg_base_addr),
    .len     (cfg_len),
    .advance (ag_advance),
    .addr    (ag_addr),
    .last    (ag_last),
    .empty   (ag_empty)
  );

  // start_ready stays low until the first edge after reset release.
  assign ready_en_d = 1'b1;

  // Next-state, read issue and config latch.
  always_comb begin
    state_d      = state_q;
    cfg_d        = cfg_q;
    nhtp_re_d    = 1'b0;
    nhtp_raddr_d = nhtp_raddr_q;
    flush_cnt_d  = flush_cnt_q;
    ag_load      = 1'b0;
    ag_advance   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_valid && start_ready) begin
          cfg_d.pkt_bw  = cfg_pkt_bw;
          cfg_d.sys_bw  = cfg_sys_bw;
          cfg_d.subband = cfg_subband;
          cfg_d.gamma   = cfg_gamma;
          cfg_d.n_tx    = cfg_n_tx;
          cfg_d.ch4     = cfg_4ch;
          ag_load       = 1'b1;
          state_d       = (cfg_len == '0) ? ST_DONE : ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (abort_i) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = FC_W'(RD_LAT);
        end else begin
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        if (abort_i) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = FC_W'(RD_LAT);
        end else if (out_ready && !ag_empty) begin
          nhtp_re_d    = 1'b1;
          nhtp_raddr_d = ag_addr;
          ag_advance   = 1'b1;
          if (ag_last) begin
            state_d     = ST_FLUSH;
            flush_cnt_d = FC_W'(RD_LAT);
          end
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_q == '0) begin
          state_d = ST_DONE;
        end else begin
          flush_cnt_d = flush_cnt_q - FC_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; everything clears on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cfg_q        <= '0;
      nhtp_re_q    <= 1'b0;
      nhtp_raddr_q <= '0;
      flush_cnt_q  <= '0;
      ready_en_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cfg_q        <= cfg_d;
      nhtp_re_q    <= nhtp_re_d;
      nhtp_raddr_q <= nhtp_raddr_d;
      flush_cnt_q  <= flush_cnt_d;
      ready_en_q   <= ready_en_d;
    end
  end

  assign start_ready               = ready_en_q && (state_q == ST_IDLE);
  assign busy                      = (state_q != ST_IDLE);
  assign done                      = (state_q == ST_DONE);
  assign dbg_state                 = state_q;
  assign nhtp_re                   = nhtp_re_q;
  assign nhtp_raddr                = nhtp_raddr_q;
  assign txconfig_bw               = cfg_q.pkt_bw;
  assign sys_bw_mode               = cfg_q.sys_bw;
  assign config_mu_subband_present = cfg_q.subband;
  assign config_gamma_rotation     = cfg_q.gamma;
  assign n_tx                      = cfg_q.n_tx;
  assign nhtp_4ch                  = cfg_q.ch4;

endmodule

// File: tb/tb_qcs_dyn_pre_seq_ctrl.sv
// Bench for qcs_dyn_pre_seq_ctrl (default build; the abort scenario is
// compiled in when QCS_DYN_PRE_SEQ_ABORT_EN is defined).
`timescale 1ns/1ps
module tb_qcs_dyn_pre_seq_ctrl;

  localparam int ADDR_DW = 14;
  localparam int RD_LAT  = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n = 1'b1;

  logic               start_valid = 1'b0;
  logic               start_ready;
  logic [1:0]         cfg_pkt_bw = '0, cfg_sys_bw = '0;
  logic [7:0]         cfg_subband = '0;
  logic [3:0]         cfg_gamma = '0, cfg_n_tx = '0;
  logic               cfg_4ch = 1'b0;
  logic [ADDR_DW-1:0] cfg_base_addr = '0;
  logic [ADDR_DW:0]   cfg_len = '0;
  logic               out_ready = 1'b1;
`ifdef QCS_DYN_PRE_SEQ_ABORT_EN
  logic               abort = 1'b0;
`endif
  logic               nhtp_re;
  logic [ADDR_DW-1:0] nhtp_raddr;
  logic [1:0]         txconfig_bw, sys_bw_mode;
  logic [7:0]         config_mu_subband_present;
  logic [3:0]         config_gamma_rotation, n_tx;
  logic               nhtp_4ch, busy, done;
  logic [2:0]         dbg_state;

  qcs_dyn_pre_seq_ctrl dut (
    .clk                       (clk),
    .reset_n                   (reset_n),
    .start_valid               (start_valid),
    .start_ready               (start_ready),
    .cfg_pkt_bw                (cfg_pkt_bw),
    .cfg_sys_bw                (cfg_sys_bw),
    .cfg_subband               (cfg_subband),
    .cfg_gamma                 (cfg_gamma),
    .cfg_n_tx                  (cfg_n_tx),
    .cfg_4ch                   (cfg_4ch),
    .cfg_base_addr             (cfg_base_addr),
    .cfg_len                   (cfg_len),
    .out_ready                 (out_ready),
`ifdef QCS_DYN_PRE_SEQ_ABORT_EN
    .abort                     (abort),
`endif
    .nhtp_re                   (nhtp_re),
    .nhtp_raddr                (nhtp_raddr),
    .txconfig_bw               (txconfig_bw),
    .sys_bw_mode               (sys_bw_mode),
    .config_mu_subband_present (config_mu_subband_present),
    .config_gamma_rotation     (config_gamma_rotation),
    .n_tx                      (n_tx),
    .nhtp_4ch                  (nhtp_4ch),
    .busy                      (busy),
    .done                      (done),
    .dbg_state                 (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int tests_run    = 0;
  int tests_failed = 0;
  logic [ADDR_DW-1:0] got_q[$];
  logic [ADDR_DW-1:0] exp_q[$];
  int done_cnt, done_cyc, first_re_cyc, last_re_cyc, ready_cyc, stall_err;
  logic [20:0] exp_cfg;

  function automatic logic [20:0] cfg_out();
    return {txconfig_bw, sys_bw_mode, config_mu_subband_present,
            config_gamma_rotation, n_tx, nhtp_4ch};
  endfunction

  // Index of the first disagreement between got_q and exp_q, -1 if equal.
  function automatic int seq_diff();
    if (got_q.size() != exp_q.size()) return -2;
    foreach (got_q[i]) if (got_q[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  // ---------------- driver tasks ----------------
  // Presents a job and returns just after the accepting edge E0.
  task automatic start_job(input logic [ADDR_DW-1:0] base, input logic [ADDR_DW:0] len,
                           input logic [1:0] pbw, input logic [1:0] sbw,
                           input logic [7:0] sb, input logic [3:0] gm,
                           input logic [3:0] ntx, input logic c4);
    int w = 0;
    @(negedge clk);
    cfg_base_addr = base; cfg_len = len; cfg_pkt_bw = pbw; cfg_sys_bw = sbw;
    cfg_subband = sb; cfg_gamma = gm; cfg_n_tx = ntx; cfg_4ch = c4;
    out_ready = 1'b1;
    start_valid = 1'b1;
    exp_cfg = {pbw, sbw, sb, gm, ntx, c4};
    while (!start_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    tests_run++;
    if (start_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL start_hs: start_ready=%b required 1", start_ready);
    end
    @(posedge clk);
    #1 start_valid = 1'b0;
  endtask

  // Samples each cycle after E0 (cycle 0 = first cycle after E0) until the
  // cycle following done, recording reads, done timing and stall behaviour.
  task automatic collect(input int max_cyc, input bit toggle, input int abort_after);
    int c = 0;
    bit prev_or = 1'b1;
    bit fin = 1'b0;
    bit ab_fired = 1'b0;
    got_q.delete();
    done_cnt = 0; done_cyc = -1; first_re_cyc = -1; last_re_cyc = -1;
    ready_cyc = -1; stall_err = 0;
    while (!fin && c < max_cyc) begin
      @(negedge clk);
      if (nhtp_re === 1'b1) begin
        got_q.push_back(nhtp_raddr);
        if (first_re_cyc < 0) first_re_cyc = c;
        last_re_cyc = c;
        if (!prev_or) stall_err++;
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = c;
      end else if (done_cyc >= 0) begin
        ready_cyc = (start_ready === 1'b1) ? c : -1;
        fin = 1'b1;
      end
`ifdef QCS_DYN_PRE_SEQ_ABORT_EN
      abort = 1'b0;
      if (abort_after > 0 && !ab_fired && got_q.size() == abort_after) begin
        abort = 1'b1;
        ab_fired = 1'b1;
      end
`else
      ab_fired = (abort_after > 0);
`endif
      if (toggle) out_ready = ~out_ready;
      prev_or = out_ready;
      c++;
    end
    out_ready = 1'b1;
    tests_run++;
    if (!fin) begin
      tests_failed++;
      $display("FAIL job_timeout: no done/ready within %0d cycles (done_cnt=%0d)", max_cyc, done_cnt);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    tests_run++;
    if ({start_ready, busy, done, nhtp_re, nhtp_raddr, cfg_out()} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outs: rdy=%b busy=%b done=%b re=%b addr=%0d cfg=%h required all 0",
               start_ready, busy, done, nhtp_re, nhtp_raddr, cfg_out());
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (start_ready !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release: start_ready=%b busy=%b required 1/0", start_ready, busy);
    end
  endtask

  task automatic test_long_burst();
    int d;
    start_job(14'd0, 15'd10336, 2'd1, 2'd2, 8'h3C, 4'h5, 4'd4, 1'b0);
    collect(10400, 1'b0, 0);
    exp_q.delete();
    for (int i = 0; i < 10336; i++) exp_q.push_back(ADDR_DW'(i));
    d = seq_diff();
    tests_run++;
    if (d != -1) begin
      tests_failed++;
      $display("FAIL long_addrs: got %0d reads (diff at %0d) required 10336 at 0..10335", got_q.size(), d);
    end
    tests_run++;
    if (first_re_cyc != 2) begin
      tests_failed++;
      $display("FAIL long_first_re: cycle %0d required 2", first_re_cyc);
    end
    tests_run++;
    if (done_cnt != 1 || done_cyc != last_re_cyc + RD_LAT + 1) begin
      tests_failed++;
      $display("FAIL long_done: count=%0d at cycle %0d required 1 at %0d", done_cnt, done_cyc, last_re_cyc + RD_LAT + 1);
    end
    tests_run++;
    if (ready_cyc != done_cyc + 1) begin
      tests_failed++;
      $display("FAIL long_ready: start_ready cycle %0d required %0d", ready_cyc, done_cyc + 1);
    end
    tests_run++;
    if (cfg_out() !== exp_cfg) begin
      tests_failed++;
      $display("FAIL long_cfg: cfg=%h required %h", cfg_out(), exp_cfg);
    end
  endtask

  task automatic test_wrap();
    int d;
    start_job(14'd16382, 15'd4, 2'd3, 2'd1, 8'h81, 4'hA, 4'd2, 1'b1);
    collect(40, 1'b0, 0);
    exp_q = '{14'd16382, 14'd16383, 14'd0, 14'd1};
    d = seq_diff();
    tests_run++;
    if (d != -1) begin
      tests_failed++;
      $display("FAIL wrap_addrs: got %0d reads (diff at %0d) required 16382,16383,0,1", got_q.size(), d);
    end
    tests_run++;
    if (done_cnt != 1 || done_cyc != 8) begin
      tests_failed++;
      $display("FAIL wrap_done: count=%0d at cycle %0d required 1 at 8", done_cnt, done_cyc);
    end
  endtask

  task automatic test_stall();
    int d;
    start_job(14'd300, 15'd8, 2'd0, 2'd3, 8'h0F, 4'h1, 4'd8, 1'b0);
    collect(80, 1'b1, 0);
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(ADDR_DW'(300 + i));
    d = seq_diff();
    tests_run++;
    if (d != -1) begin
      tests_failed++;
      $display("FAIL stall_addrs: got %0d reads (diff at %0d) required 8 at 300..307", got_q.size(), d);
    end
    tests_run++;
    if (stall_err != 0) begin
      tests_failed++;
      $display("FAIL stall_re: %0d reads after stalled edges required 0", stall_err);
    end
    tests_run++;
    if (done_cnt != 1 || done_cyc != last_re_cyc + RD_LAT + 1) begin
      tests_failed++;
      $display("FAIL stall_done: count=%0d at cycle %0d required 1 at %0d", done_cnt, done_cyc, last_re_cyc + RD_LAT + 1);
    end
  endtask

  task automatic test_zero_len();
    start_job(14'd5, 15'd0, 2'd2, 2'd3, 8'hA5, 4'h9, 4'd7, 1'b1);
    collect(20, 1'b0, 0);
    tests_run++;
    if (got_q.size() != 0) begin
      tests_failed++;
      $display("FAIL zero_reads: %0d reads required 0", got_q.size());
    end
    tests_run++;
    if (done_cnt != 1 || done_cyc != 0 || ready_cyc != 1) begin
      tests_failed++;
      $display("FAIL zero_done: count=%0d at %0d ready at %0d required 1 at 0 ready at 1", done_cnt, done_cyc, ready_cyc);
    end
    tests_run++;
    if (cfg_out() !== exp_cfg) begin
      tests_failed++;
      $display("FAIL zero_cfg: cfg=%h required %h", cfg_out(), exp_cfg);
    end
  endtask

  task automatic test_reset_mid_job();
    int n = 0, w = 0, bad = 0, d;
    start_job(14'd200, 15'd20, 2'd1, 2'd1, 8'hFF, 4'hF, 4'd15, 1'b1);
    while (n < 5 && w < 40) begin
      @(negedge clk);
      if (nhtp_re === 1'b1) n++;
      w++;
    end
    tests_run++;
    if (n != 5) begin
      tests_failed++;
      $display("FAIL mid_reads: %0d reads before reset required 5", n);
    end
    reset_n = 1'b0;
    #1;
    tests_run++;
    if ({start_ready, busy, done, nhtp_re, nhtp_raddr, cfg_out()} !== '0) begin
      tests_failed++;
      $display("FAIL mid_reset_outs: rdy=%b busy=%b done=%b re=%b addr=%0d cfg=%h required all 0",
               start_ready, busy, done, nhtp_re, nhtp_raddr, cfg_out());
    end
    repeat (3) begin
      @(negedge clk);
      if (nhtp_re !== 1'b0 || done !== 1'b0) bad++;
    end
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (nhtp_re !== 1'b0 || done !== 1'b0 || busy !== 1'b0) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL mid_quiet: %0d cycles with activity after reset required 0", bad);
    end
    start_job(14'd50, 15'd3, 2'd2, 2'd0, 8'h12, 4'h3, 4'd1, 1'b0);
    collect(40, 1'b0, 0);
    exp_q = '{14'd50, 14'd51, 14'd52};
    d = seq_diff();
    tests_run++;
    if (d != -1 || done_cnt != 1 || done_cyc != 7) begin
      tests_failed++;
      $display("FAIL mid_restart: %0d reads (diff %0d) done %0d at %0d required 50..52 done 1 at 7",
               got_q.size(), d, done_cnt, done_cyc);
    end
  endtask

`ifdef QCS_DYN_PRE_SEQ_ABORT_EN
  task automatic test_abort();
    int d;
    start_job(14'd0, 15'd100, 2'd0, 2'd0, 8'h01, 4'h2, 4'd3, 1'b0);
    collect(60, 1'b0, 3);
    exp_q = '{14'd0, 14'd1, 14'd2};
    d = seq_diff();
    tests_run++;
    if (d != -1) begin
      tests_failed++;
      $display("FAIL abort_reads: %0d reads (diff %0d) required 3 at 0..2", got_q.size(), d);
    end
    // abort is raised in the cycle of the third strobe and sampled on the
    // following edge, which loads the flush counter.
    tests_run++;
    if (done_cnt != 1 || done_cyc != last_re_cyc + RD_LAT + 2 || ready_cyc != done_cyc + 1) begin
      tests_failed++;
      $display("FAIL abort_done: count=%0d at %0d ready %0d required 1 at %0d ready %0d",
               done_cnt, done_cyc, ready_cyc, last_re_cyc + RD_LAT + 2, last_re_cyc + RD_LAT + 3);
    end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_long_burst();
    test_wrap();
    test_stall();
    test_zero_len();
    test_reset_mid_job();
`ifdef QCS_DYN_PRE_SEQ_ABORT_EN
    test_abort();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
